// File: rtl/operand_entry_ctrl.sv
// Operand entry controller for the 16-bit signed calculator.
// Acknowledges keypad tokens, builds operands A/B in decimal, issues them to
// the ALU over valid/ready, and chains the ALU result as the next operand A.
module operand_entry_ctrl #(
  parameter int unsigned MAG_MAX = 32767
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        read_input,
  output logic        key_read,
  input  logic [3:0]  keypad_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [2:0]  op_code,
  output logic        calc_valid,
  input  logic        calc_ready,
  input  logic [15:0] result_in,
  output logic [15:0] display_value,
  output logic        entry_error
);

  typedef enum logic [1:0] {ENTRY_A, ENTRY_B, ISSUE, SHOW} main_t;
  typedef enum logic       {H_IDLE, H_WAIT_LOW} hs_t;
  typedef enum logic [2:0] {K_NONE, K_DIGIT, K_NEG, K_OP, K_EQ} kind_t;

  main_t       main_q, main_d;
  hs_t         hs_q, hs_d;
  logic        key_read_q, key_read_d;
  logic        tok_v_q, tok_v_d;
  logic        tok_eq_q, tok_eq_d;
  logic [2:0]  tok_op_q, tok_op_d;
  logic [3:0]  tok_dig_q, tok_dig_d;
  logic [15:0] a_mag_q, a_mag_d;
  logic        a_neg_q, a_neg_d;
  logic [15:0] b_mag_q, b_mag_d;
  logic        b_neg_q, b_neg_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [2:0]  op_code_q, op_code_d;
  logic        calc_valid_q, calc_valid_d;
  logic [15:0] r_q, r_d;
  logic [15:0] disp_q, disp_d;
  logic        err_q, err_d;

  kind_t       kind;
  logic [15:0] acc_mag;
  logic [19:0] mag_next;
  logic        digit_fits;
  logic [15:0] a_val, b_val;

  assign key_read      = key_read_q;
  assign op_a          = op_a_q;
  assign op_b          = op_b_q;
  assign op_code       = op_code_q;
  assign calc_valid    = calc_valid_q;
  assign display_value = disp_q;
  assign entry_error   = err_q;

  // Token classification, digit arithmetic and signed operand views.
  always_comb begin
    kind = K_NONE;
    if (tok_eq_q)                                          kind = K_EQ;
    else if (tok_op_q == 3'b001)                           kind = K_NEG;
    else if (tok_op_q == 3'b010 || tok_op_q == 3'b011 ||
             tok_op_q == 3'b100)                           kind = K_OP;
    else if (tok_op_q == 3'b000)                           kind = K_DIGIT;
    acc_mag    = (main_q == ENTRY_B) ? b_mag_q : a_mag_q;
    mag_next   = 20'(acc_mag) * 20'd10 + 20'(tok_dig_q);
    digit_fits = (mag_next <= 20'(MAG_MAX));
    a_val      = a_neg_q ? (16'd0 - a_mag_q) : a_mag_q;
    b_val      = b_neg_q ? (16'd0 - b_mag_q) : b_mag_q;
  end

  // Next-state logic for the key handshake, main FSM, datapath and display.
  always_comb begin
    main_d       = main_q;
    hs_d         = hs_q;
    key_read_d   = 1'b0;
    tok_v_d      = 1'b0;
    tok_eq_d     = tok_eq_q;
    tok_op_d     = tok_op_q;
    tok_dig_d    = tok_dig_q;
    a_mag_d      = a_mag_q;
    a_neg_d      = a_neg_q;
    b_mag_d      = b_mag_q;
    b_neg_d      = b_neg_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    calc_valid_d = calc_valid_q;
    r_d          = r_q;
    err_d        = err_q;
    disp_d       = disp_q;

    unique case (hs_q)
      H_IDLE: begin
        if (read_input && main_q != ISSUE) begin
          tok_eq_d   = equal_input;
          tok_op_d   = operator_input;
          tok_dig_d  = keypad_input;
          tok_v_d    = 1'b1;
          key_read_d = 1'b1;
          hs_d       = H_WAIT_LOW;
        end
      end
      H_WAIT_LOW: if (!read_input) hs_d = H_IDLE;
      default:    hs_d = H_IDLE;
    endcase

    if (tok_v_q && (kind == K_OP || kind == K_EQ)) err_d = 1'b0;

    unique case (main_q)
      ENTRY_A: if (tok_v_q) begin
        unique case (kind)
          K_DIGIT: if (digit_fits) a_mag_d = mag_next[15:0]; else err_d = 1'b1;
          K_NEG:   a_neg_d = ~a_neg_q;
          K_OP: begin
            op_a_d    = a_val;
            op_code_d = tok_op_q;
            b_mag_d   = '0;
            b_neg_d   = 1'b0;
            main_d    = ENTRY_B;
          end
          default: ;
        endcase
      end
      ENTRY_B: if (tok_v_q) begin
        unique case (kind)
          K_DIGIT: if (digit_fits) b_mag_d = mag_next[15:0]; else err_d = 1'b1;
          K_NEG:   b_neg_d = ~b_neg_q;
          K_OP:    op_code_d = tok_op_q;
          K_EQ: begin
            op_b_d       = b_val;
            calc_valid_d = 1'b1;
            main_d       = ISSUE;
          end
          default: ;
        endcase
      end
      ISSUE: if (calc_ready) begin
        r_d          = result_in;
        calc_valid_d = 1'b0;
        main_d       = SHOW;
      end
      SHOW: if (tok_v_q) begin
        unique case (kind)
          K_DIGIT: begin
            a_mag_d = 16'(tok_dig_q);
            a_neg_d = 1'b0;
            main_d  = ENTRY_A;
          end
          K_NEG: r_d = 16'd0 - r_q;
          K_OP: begin
            op_a_d    = r_q;
            op_code_d = tok_op_q;
            b_mag_d   = '0;
            b_neg_d   = 1'b0;
            main_d    = ENTRY_B;
          end
          default: ;
        endcase
      end
      default: main_d = ENTRY_A;
    endcase

    unique case (main_q)
      ENTRY_A: disp_d = a_val;
      ENTRY_B: disp_d = b_val;
      ISSUE:   disp_d = op_b_q;
      SHOW:    disp_d = r_q;
      default: disp_d = '0;
    endcase
  end

  // State and datapath registers; reset aborts any pending acknowledge or issue.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      main_q       <= ENTRY_A;
      hs_q         <= H_IDLE;
      key_read_q   <= 1'b0;
      tok_v_q      <= 1'b0;
      tok_eq_q     <= 1'b0;
      tok_op_q     <= '0;
      tok_dig_q    <= '0;
      a_mag_q      <= '0;
      a_neg_q      <= 1'b0;
      b_mag_q      <= '0;
      b_neg_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      calc_valid_q <= 1'b0;
      r_q          <= '0;
      disp_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      main_q       <= main_d;
      hs_q         <= hs_d;
      key_read_q   <= key_read_d;
      tok_v_q      <= tok_v_d;
      tok_eq_q     <= tok_eq_d;
      tok_op_q     <= tok_op_d;
      tok_dig_q    <= tok_dig_d;
      a_mag_q      <= a_mag_d;
      a_neg_q      <= a_neg_d;
      b_mag_q      <= b_mag_d;
      b_neg_q      <= b_neg_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      calc_valid_q <= calc_valid_d;
      r_q          <= r_d;
      disp_q       <= disp_d;
      err_q        <= err_d;
    end
  end

endmodule
